// File: rtl/divide_tokens.sv
// divide_tokens: per-channel token-rate divider with a shared, runtime-loadable divisor.
// Each channel emits one registered output pulse per group of d input tokens.
module divide_tokens #(
    parameter int N_CH       = 4,
    parameter int DIV_W      = 4,
    parameter int DIV_RESET  = 2,
    parameter int EMIT_FIRST = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_CH-1:0]         a,
    input  logic [N_CH-1:0]         clr,
    input  logic [DIV_W-1:0]        div,
    input  logic                    div_load,
    output logic [N_CH-1:0]         b,
    output logic [N_CH*DIV_W-1:0]   cnt,
    output logic [DIV_W-1:0]        div_act
);
    logic [DIV_W-1:0]      d;
    logic [DIV_W-1:0]      d_new;
    logic [N_CH-1:0]       b_nxt;
    logic [N_CH*DIV_W-1:0] cnt_nxt;

    // A stored divisor of zero behaves as one.
    assign d     = (div_act == '0) ? DIV_W'(1) : div_act;
    assign d_new = (div == '0) ? DIV_W'(1) : div;

    always_comb begin
        b_nxt   = '0;
        cnt_nxt = cnt;
        for (int i = 0; i < N_CH; i++) begin
            if (div_load) begin
                // A token in the load cycle opens the new group; with d'==1 it also closes it.
                cnt_nxt[i*DIV_W +: DIV_W] = (a[i] && d_new != DIV_W'(1)) ? DIV_W'(1) : '0;
                b_nxt[i] = a[i] && (EMIT_FIRST != 0 || d_new == DIV_W'(1));
            end else if (clr[i]) begin
                cnt_nxt[i*DIV_W +: DIV_W] = '0;
            end else if (a[i]) begin
                b_nxt[i] = (EMIT_FIRST != 0) ? (cnt[i*DIV_W +: DIV_W] == '0)
                                             : (cnt[i*DIV_W +: DIV_W] == d - DIV_W'(1));
                cnt_nxt[i*DIV_W +: DIV_W] = (cnt[i*DIV_W +: DIV_W] == d - DIV_W'(1))
                                            ? '0 : cnt[i*DIV_W +: DIV_W] + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            b       <= '0;
            cnt     <= '0;
            div_act <= DIV_W'(DIV_RESET);
        end else begin
            b       <= b_nxt;
            cnt     <= cnt_nxt;
            if (div_load) div_act <= div;
        end
    end
endmodule

// File: tb/tb_divide_tokens.sv
// tb_divide_tokens: scoreboard bench driving EMIT_FIRST=0 and EMIT_FIRST=1 instances with shared stimulus.
module tb_divide_tokens;
    localparam int N = 4;
    localparam int W = 4;

    logic clk = 0;
    logic rst = 0;
    logic [N-1:0] a = '0;
    logic [N-1:0] clr = '0;
    logic [W-1:0] div = '0;
    logic div_load = 0;
    logic [N-1:0] b0, b1;
    logic [N*W-1:0] cnt0, cnt1;
    logic [W-1:0] da0, da1;

    divide_tokens #(.N_CH(N), .DIV_W(W), .DIV_RESET(2), .EMIT_FIRST(0)) dut0 (
        .clk(clk), .rst(rst), .a(a), .clr(clr), .div(div), .div_load(div_load),
        .b(b0), .cnt(cnt0), .div_act(da0));
    divide_tokens #(.N_CH(N), .DIV_W(W), .DIV_RESET(2), .EMIT_FIRST(1)) dut1 (
        .clk(clk), .rst(rst), .a(a), .clr(clr), .div(div), .div_load(div_load),
        .b(b1), .cnt(cnt1), .div_act(da1));

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0]   b0;
        logic [N-1:0]   b1;
        logic [N*W-1:0] c0;
        logic [N*W-1:0] c1;
        logic [W-1:0]   da;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad = 0;
    int g0[N];
    int g1[N];
    int m_div = 2;
    int tok[N];
    int outs0[N];
    int outs1[N];
    bit mon_en = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h at %0t", name, act, want, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            g0[i] = 0;
            g1[i] = 0;
        end
        m_div = 2;
    endtask

    // Reference: tokens seen in the current group, as plain integers.
    task automatic step(input logic [N-1:0] ta, input logic [N-1:0] tc, input logic ld, input logic [W-1:0] dv);
        exp_t e;
        int d;
        @(posedge clk);
        #2;
        a = ta; clr = tc; div_load = ld; div = dv;
        e = '0;
        if (ld) m_div = int'(dv);
        d = (m_div == 0) ? 1 : m_div;
        for (int i = 0; i < N; i++) begin
            tok[i] += int'(ta[i]);
            if (ld) begin
                g0[i] = ta[i] ? (1 % d) : 0;
                g1[i] = ta[i] ? (1 % d) : 0;
                e.b0[i] = ta[i] && d == 1;
                e.b1[i] = ta[i];
            end else if (tc[i]) begin
                g0[i] = 0;
                g1[i] = 0;
            end else if (ta[i]) begin
                g0[i]++;
                e.b0[i] = (g0[i] == d);
                if (g0[i] == d) g0[i] = 0;
                e.b1[i] = (g1[i] == 0);
                g1[i] = (g1[i] + 1) % d;
            end
            e.c0[i*W +: W] = W'(g0[i]);
            e.c1[i*W +: W] = W'(g1[i]);
        end
        e.da = W'(m_div);
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step('0, '0, 1'b0, '0);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en && q.size() > 0) begin
                e = q.pop_front();
                chk("b0", 32'(b0), 32'(e.b0));
                chk("b1", 32'(b1), 32'(e.b1));
                chk("cnt0", 32'(cnt0), 32'(e.c0));
                chk("cnt1", 32'(cnt1), 32'(e.c1));
                chk("div_act0", 32'(da0), 32'(e.da));
                chk("div_act1", 32'(da1), 32'(e.da));
                for (int i = 0; i < N; i++) begin
                    outs0[i] += int'(b0[i]);
                    outs1[i] += int'(b1[i]);
                end
            end
        end
    end

    initial begin
        model_reset();
        for (int i = 0; i < N; i++) begin tok[i] = 0; outs0[i] = 0; outs1[i] = 0; end
        repeat (2) @(posedge clk);
        #1;
        chk("rst_b", 32'({b1, b0}), 32'(0));
        chk("rst_cnt", 32'(cnt0 | cnt1), 32'(0));
        chk("rst_div_act", 32'(da0), 32'(2));
        @(posedge clk);
        #2;
        rst = 1;
        mon_en = 1;

        // Ratio under reset divisor.
        for (int k = 0; k < 200; k++) step(N'($urandom), '0, 1'b0, '0);
        idle(20);
        for (int i = 0; i < N; i++) begin
            chk("ratio_floor", 32'(outs0[i]), 32'(tok[i] / 2));
            chk("ratio_ceil", 32'(outs1[i]), 32'((tok[i] + 1) / 2));
        end

        // Async reset mid-stream.
        step(4'b1111, '0, 1'b0, '0);
        step(4'b1111, '0, 1'b0, '0);
        mon_en = 0;
        #1;
        rst = 0;
        #1;
        chk("async_b", 32'({b1, b0}), 32'(0));
        chk("async_cnt", 32'(cnt0 | cnt1), 32'(0));
        a = '0;
        q.delete();
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        rst = 1;
        mon_en = 1;

        // div=3, 7 tokens on channel 0.
        step('0, '0, 1'b1, 4'd3);
        for (int k = 0; k < 7; k++) step(4'b0001, '0, 1'b0, '0);
        idle(2);
        chk("d3_cnt0", 32'(cnt0[W-1:0]), 32'(1));

        // div=4, 9 tokens on channel 1.
        step('0, '0, 1'b1, 4'd4);
        for (int k = 0; k < 9; k++) step(4'b0010, '0, 1'b0, '0);
        idle(2);

        // div=0 then div=1, alternating tokens.
        step('0, '0, 1'b1, 4'd0);
        for (int k = 0; k < 6; k++) step((k % 2) ? 4'b0000 : 4'b1111, '0, 1'b0, '0);
        step('0, '0, 1'b1, 4'd1);
        for (int k = 0; k < 6; k++) step((k % 2) ? 4'b0000 : 4'b1111, '0, 1'b0, '0);
        idle(2);

        // clr and token together on channel 2 at cnt=2, d=3.
        step('0, '0, 1'b1, 4'd3);
        step(4'b0100, '0, 1'b0, '0);
        step(4'b0100, '0, 1'b0, '0);
        step(4'b1111, 4'b0100, 1'b0, '0);
        idle(2);

        // div_load with a token while cnt3=4 under d=5.
        step('0, '0, 1'b1, 4'd5);
        for (int k = 0; k < 4; k++) step(4'b1000, '0, 1'b0, '0);
        step(4'b1000, '0, 1'b1, 4'd2);
        step(4'b1000, '0, 1'b0, '0);
        idle(2);

        // Random mix of tokens, clears and loads.
        for (int k = 0; k < 400; k++)
            step(N'($urandom), ($urandom_range(0, 7) == 0) ? N'($urandom) : '0,
                 $urandom_range(0, 15) == 0, W'($urandom));
        idle(2);

        repeat (3) @(posedge clk);
        #2;
        chk("queue_drained", 32'(q.size()), 32'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
